// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared constants, types and helpers for the writeback stage
package wb_stage_pkg;

    localparam int WORD = 32;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Size code 3 behaves as a word access, so it must also be word-aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if (size == LS_HALF) bad = offset[0];
        else if (size != LS_BYTE) bad = (offset != 2'd0);
        return bad;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB retiring instruction handshake
interface wb_stage_if #(
    parameter int BITS = 5
);
    import wb_stage_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_reg_write;
    logic             in_mem_to_reg;
    logic [BITS-1:0]  in_dest;
    logic [WORD-1:0]  in_alu_result;
    logic [1:0]       in_load_size;
    logic             in_load_unsigned;

    modport master (
        output in_valid, in_reg_write, in_mem_to_reg, in_dest,
               in_alu_result, in_load_size, in_load_unsigned,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_reg_write, in_mem_to_reg, in_dest,
               in_alu_result, in_load_size, in_load_unsigned,
        output in_ready
    );

endinterface

// File: rtl/wb_stage_load_extract.sv
// rtl/wb_stage_load_extract.sv - big-endian byte/half/word select with sign or zero extension
module load_extract
    import wb_stage_pkg::*;
(
    input  logic [WORD-1:0] rdata,
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic            is_unsigned,
    output logic [WORD-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
    end

    assign half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        data = rdata;
        case (size)
            LS_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            LS_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS writeback stage: result select, regfile write port, load wait, retire count
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int bits = clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    wb_stage_if.slave        up,
    input  logic [WORD-1:0]  mem_rdata,
    input  logic             mem_rvalid,
    output logic             write,
    output logic [bits-1:0]  address_dest,
    output logic [WORD-1:0]  write_data,
    output logic             align_err,
    output logic             rvalid_err,
    output logic [31:0]      retired_count
);

    wb_state_t       state;
    logic [bits-1:0] ld_dest;
    logic            ld_reg_write;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [1:0]      ld_offset;
    logic [WORD-1:0] ld_data;
    logic            alu_writes;
    logic            ld_writes;

    assign up.in_ready = (state == ST_IDLE);

    load_extract u_extract (
        .rdata       (mem_rdata),
        .size        (ld_size),
        .offset      (ld_offset),
        .is_unsigned (ld_unsigned),
        .data        (ld_data)
    );

    assign alu_writes = up.in_reg_write && (up.in_dest != '0);
    assign ld_writes  = ld_reg_write && (ld_dest != '0);

    // address_dest/write_data only move when a write actually happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            write         <= 1'b0;
            address_dest  <= '0;
            write_data    <= '0;
            align_err     <= 1'b0;
            rvalid_err    <= 1'b0;
            retired_count <= '0;
            ld_dest       <= '0;
            ld_reg_write  <= 1'b0;
            ld_size       <= LS_BYTE;
            ld_unsigned   <= 1'b0;
            ld_offset     <= 2'd0;
        end else begin
            write     <= 1'b0;
            align_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_rvalid) rvalid_err <= 1'b1;
                    if (up.in_valid) begin
                        if (!up.in_mem_to_reg) begin
                            write         <= alu_writes;
                            retired_count <= retired_count + 32'd1;
                            if (alu_writes) begin
                                address_dest <= up.in_dest;
                                write_data   <= up.in_alu_result;
                            end
                        end else if (is_misaligned(up.in_load_size, up.in_alu_result[1:0])) begin
                            align_err <= 1'b1;
                        end else begin
                            ld_dest      <= up.in_dest;
                            ld_reg_write <= up.in_reg_write;
                            ld_size      <= up.in_load_size;
                            ld_unsigned  <= up.in_load_unsigned;
                            ld_offset    <= up.in_alu_result[1:0];
                            state        <= ST_WAIT_MEM;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        write         <= ld_writes;
                        retired_count <= retired_count + 32'd1;
                        state         <= ST_IDLE;
                        if (ld_writes) begin
                            address_dest <= ld_dest;
                            write_data   <= ld_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
